// File: rtl/dqs_gen_pkg.sv
// Shared types and constants for the DDR write-strobe generator.
// The beat counter is sized to hold a full burst and the longest pre/postamble.
package dqs_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_BURST = 2'd2,
      ST_POST  = 2'd3
   } dqs_state_e;

   localparam int MAX_PRE_POST = 7;

   function automatic int cnt_width(input int len_w);
      int pp_w;
      pp_w = $clog2(MAX_PRE_POST + 1);
      return (len_w > pp_w) ? len_w : pp_w;
   endfunction

endpackage

// File: rtl/dqs_beat_cnt.sv
// Loadable down-counter with terminal-count flag, shared by PRE/BURST/POST.
// The next count is exported so the owner can register ready one beat early.
module dqs_beat_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_nxt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_nxt_o = cnt_d;
   assign tc_o      = (cnt_q == '0);

endmodule

// File: rtl/dqs_wr_strobe_gen.sv
// DDR write DQS generator: preamble, toggling burst, postamble, tristate.
// One clock equals one DQS bit time; all strobe outputs come from flops.
module dqs_wr_strobe_gen
   import dqs_gen_pkg::*;
#(
   parameter int PRE_BEATS  = 2,
   parameter int POST_BEATS = 1,
   parameter int LEN_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   input  logic [LEN_W-1:0] wr_len,
   output logic             wr_ready,
   input  logic             force_off,
   output logic             dqs_i,
   output logic             dqs_t,
   output logic             data_en,
   output logic             busy
);

   localparam int CNT_W   = cnt_width(LEN_W);
   localparam int PRE_M1  = (PRE_BEATS > 0) ? PRE_BEATS - 1 : 0;
   localparam int POST_M1 = (POST_BEATS > 0) ? POST_BEATS - 1 : 0;
   localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_M1);
   localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_M1);

   dqs_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             dqs_i_q, dqs_i_d;
   logic             dqs_t_q, dqs_t_d;
   logic             data_en_q, data_en_d;
   logic             busy_q, busy_d;
   logic             rdy_q, rdy_d;
   logic             accept;
   logic             ld, dec, tc;
   logic [CNT_W-1:0] ld_val, cnt_nxt;

   // force_off must block an accept in the same cycle, so it gates ready directly
   assign wr_ready = rdy_q & ~force_off;
   assign accept   = wr_valid & wr_ready;

   dqs_beat_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ld),
      .load_val_i (ld_val),
      .dec_i      (dec),
      .cnt_nxt_o  (cnt_nxt),
      .tc_o       (tc)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ld      = 1'b0;
      ld_val  = '0;
      dec     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               len_d = wr_len;
               ld    = 1'b1;
               if (PRE_BEATS > 0) begin
                  state_d = ST_PRE;
                  ld_val  = PRE_LD;
               end else begin
                  state_d = ST_BURST;
                  ld_val  = CNT_W'(wr_len);
               end
            end
         end
         ST_PRE: begin
            if (tc) begin
               state_d = ST_BURST;
               ld      = 1'b1;
               ld_val  = CNT_W'(len_q);
            end else begin
               dec = 1'b1;
            end
         end
         ST_BURST: begin
            if (tc) begin
               if (accept) begin
                  len_d  = wr_len;
                  ld     = 1'b1;
                  ld_val = CNT_W'(wr_len);
               end else if (POST_BEATS > 0) begin
                  state_d = ST_POST;
                  ld      = 1'b1;
                  ld_val  = POST_LD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               dec = 1'b1;
            end
         end
         ST_POST: begin
            if (tc) begin
               state_d = ST_IDLE;
            end else begin
               dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (force_off) begin
         state_d = ST_IDLE;
         ld      = 1'b0;
         dec     = 1'b0;
      end
   end

   // Outputs decode the next state so they land in the same flop edge
   always_comb begin
      dqs_t_d   = (state_d == ST_IDLE);
      data_en_d = (state_d == ST_BURST);
      busy_d    = (state_d != ST_IDLE);
      dqs_i_d   = 1'b0;
      if (state_d == ST_BURST) begin
         dqs_i_d = (state_q == ST_BURST) ? ~dqs_i_q : 1'b1;
      end
      rdy_d = (state_d == ST_IDLE) ||
              ((state_d == ST_BURST) && (cnt_nxt == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         dqs_i_q   <= 1'b0;
         dqs_t_q   <= 1'b1;
         data_en_q <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         dqs_i_q   <= dqs_i_d;
         dqs_t_q   <= dqs_t_d;
         data_en_q <= data_en_d;
         busy_q    <= busy_d;
         rdy_q     <= rdy_d;
      end
   end

   assign dqs_i   = dqs_i_q;
   assign dqs_t   = dqs_t_q;
   assign data_en = data_en_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_dqs_wr_strobe_gen.sv
// Bench for dqs_wr_strobe_gen: default instance plus a no-pre/postamble one.
// A schedule-of-beats model predicts every output each cycle.
module tb_dqs_wr_strobe_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic [3:0] wr_len;
   logic       force_off;

   logic wr_ready, dqs_i, dqs_t, data_en, busy;
   logic wr_ready0, dqs_i0, dqs_t0, data_en0, busy0;

   always #5 clk = ~clk;

   dqs_wr_strobe_gen u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_len    (wr_len),
      .wr_ready  (wr_ready),
      .force_off (force_off),
      .dqs_i     (dqs_i),
      .dqs_t     (dqs_t),
      .data_en   (data_en),
      .busy      (busy)
   );

   dqs_wr_strobe_gen #(
      .PRE_BEATS  (0),
      .POST_BEATS (0),
      .LEN_W      (4)
   ) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_len    (wr_len),
      .wr_ready  (wr_ready0),
      .force_off (force_off),
      .dqs_i     (dqs_i0),
      .dqs_t     (dqs_t0),
      .data_en   (data_en0),
      .busy      (busy0)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
      end
   endtask

   // Reference: each cycle is one entry of a planned beat schedule
   typedef struct packed {
      logic t;
      logic i;
      logic en;
      logic last;
   } ent_t;

   localparam ent_t IDLE_E = ent_t'(4'b1000);

   ent_t cur [2];
   ent_t sch [2][64];
   int   sch_n [2];
   logic blk [2];

   function automatic int pre_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic int post_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   function automatic logic exp_rdy(input int k);
      return !blk[k] && (cur[k].t || cur[k].last) && !force_off;
   endfunction

   function automatic logic [4:0] expv(input int k);
      return {exp_rdy(k), cur[k].t, cur[k].i, cur[k].en, ~cur[k].t};
   endfunction

   function automatic logic [4:0] obs(input int k);
      if (k == 0) return {wr_ready, dqs_t, dqs_i, data_en, busy};
      return {wr_ready0, dqs_t0, dqs_i0, data_en0, busy0};
   endfunction

   task automatic push(input int k, input ent_t e);
      sch[k][sch_n[k]] = e;
      sch_n[k]++;
   endtask

   task automatic plan(input int k, input int npre, input int len,
                       input int npost, input logic ph);
      ent_t e;
      sch_n[k] = 0;
      for (int p = 0; p < npre; p++) push(k, ent_t'(4'b0000));
      for (int b = 0; b <= len; b++) begin
         e.t    = 1'b0;
         e.i    = ph ^ ((b % 2) == 1);
         e.en   = 1'b1;
         e.last = (b == len);
         push(k, e);
      end
      for (int p = 0; p < npost; p++) push(k, ent_t'(4'b0000));
   endtask

   task automatic pop(input int k, output ent_t e);
      if (sch_n[k] == 0) begin
         e = IDLE_E;
      end else begin
         e = sch[k][0];
         for (int j = 1; j < sch_n[k]; j++) sch[k][j-1] = sch[k][j];
         sch_n[k]--;
      end
   endtask

   task automatic step(input int k);
      logic acc;
      ent_t e;
      acc = wr_valid && exp_rdy(k);
      if (force_off) begin
         sch_n[k] = 0;
         cur[k]   = IDLE_E;
      end else begin
         if (acc) begin
            if (cur[k].t) plan(k, pre_of(k), int'(wr_len), post_of(k), 1'b1);
            else          plan(k, 0, int'(wr_len), post_of(k), ~cur[k].i);
         end
         pop(k, e);
         cur[k] = e;
      end
      blk[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         cur[k]   = IDLE_E;
         sch_n[k] = 0;
         blk[k]   = 1'b1;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               cur[k]   = IDLE_E;
               sch_n[k] = 0;
               blk[k]   = 1'b1;
            end else begin
               step(k);
            end
         end
      end
   end

   // Per-cycle comparison plus window statistics for the directed cases
   logic trace_on = 1'b0;
   int   c_t0, c_en, c_rise, c_tog_bad, c0_t0, c0_hi;
   logic p_en, p_i;

   task automatic trace_start();
      c_t0 = 0; c_en = 0; c_rise = 0; c_tog_bad = 0;
      c0_t0 = 0; c0_hi = 0;
      p_en = 1'b0; p_i = 1'b0;
      trace_on = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("model_a", 32'(obs(0)), 32'(expv(0)));
         chk("model_b", 32'(obs(1)), 32'(expv(1)));
         if (trace_on) begin
            if (!dqs_t) c_t0++;
            if (data_en) c_en++;
            if (data_en && !p_en) c_rise++;
            if (data_en && p_en && (dqs_i == p_i)) c_tog_bad++;
            if (!dqs_t0) c0_t0++;
            if (!dqs_t0 && dqs_i0) c0_hi++;
            p_en = data_en;
            p_i  = dqs_i;
         end
      end
   end

   task automatic req(input logic [3:0] len);
      logic ok;
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_len   = len;
      for (int n = 0; n < 64 && !ok; n++) begin
         @(negedge clk);
         if (wr_ready) ok = 1'b1;
         @(posedge clk);
      end
      #1 wr_valid = 1'b0;
      chk("req_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 80 && !ok; n++) begin
         if (!busy && !busy0) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("idle_wait", 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0] e3;
      int         k;
      rst_n = 1'b1; wr_valid = 1'b0; wr_len = '0; force_off = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", 32'({dqs_t, dqs_i, data_en, busy}), 32'h8);
      chk("rst_rdy", 32'(wr_ready), 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_rdy_low", 32'(wr_ready), 32'd0);
      @(posedge clk); #1;
      chk("rel_rdy_high", 32'(wr_ready), 32'd1);

      // Single 8-beat burst, exact cycle-by-cycle shape
      req(4'd7);
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         e3[2] = (k == 12);
         e3[0] = (k >= 3) && (k <= 10);
         e3[1] = e3[0] && (((k - 3) % 2) == 0);
         chk("seq_8beat", 32'({dqs_t, dqs_i, data_en}), 32'(e3));
      end
      @(posedge clk); #1;
      wait_idle();

      // Seamless back-to-back 4-beat bursts
      trace_start();
      req(4'd3);
      req(4'd3);
      repeat (14) @(posedge clk);
      #1 trace_on = 1'b0;
      chk("seam_t0", 32'(c_t0), 32'd11);
      chk("seam_en", 32'(c_en), 32'd8);
      chk("seam_rise", 32'(c_rise), 32'd1);
      chk("seam_toggle", 32'(c_tog_bad), 32'd0);
      wait_idle();

      // One-beat burst with no pre/postamble on the second instance
      trace_start();
      req(4'd0);
      repeat (8) @(posedge clk);
      #1 trace_on = 1'b0;
      chk("one_b_t0", 32'(c0_t0), 32'd1);
      chk("one_b_hi", 32'(c0_hi), 32'd1);
      chk("one_a_t0", 32'(c_t0), 32'd4);
      wait_idle();

      // Longest burst runs all 16 beats
      trace_start();
      req(4'd15);
      repeat (22) @(posedge clk);
      #1 trace_on = 1'b0;
      chk("max_en", 32'(c_en), 32'd16);
      chk("max_rise", 32'(c_rise), 32'd1);
      wait_idle();

      // Abort on the third burst beat
      req(4'd7);
      repeat (4) @(posedge clk);
      #1;
      chk("fo_beat3", 32'({data_en, dqs_i}), 32'h3);
      force_off = 1'b1;
      #1 chk("fo_rdy", 32'(wr_ready), 32'd0);
      @(posedge clk);
      #1 force_off = 1'b0;
      chk("fo_after", 32'({dqs_t, data_en, busy}), 32'h4);
      wait_idle();

      // Asynchronous reset during the preamble
      req(4'd7);
      #2 rst_n = 1'b0;
      #1 chk("arst_out", 32'({dqs_t, dqs_i, data_en, busy}), 32'h8);
      chk("arst_out_b", 32'({dqs_t0, data_en0}), 32'h2);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_rdy_low", 32'(wr_ready), 32'd0);
      @(posedge clk); #1;
      chk("arst_rdy_high", 32'(wr_ready), 32'd1);

      // Randomized traffic with occasional abort and reset
      for (int c = 0; c < 800; c++) begin
         wr_valid  = ($urandom_range(0, 2) != 0);
         wr_len    = 4'($urandom_range(0, 15));
         force_off = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
         @(posedge clk); #1;
      end
      wr_valid = 1'b0; force_off = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
